// File: rtl/fifo_tx_pkg.sv
// Shared types and constants for the FIFO-fed serial transmitter.
package fifo_tx_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

    localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/fifo_tx_baud.sv
// Baud counter: counts 0..CLKS_PER_BIT-1, wraps on each bit boundary and is
// held at 0 while clear is high so every state starts on a fresh bit period.
module fifo_tx_baud #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic bit_tick,
    output logic pre_tick
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // pre_tick flags the clk before bit_tick so callers can register a pulse
    // that lands exactly on the last clk of a bit.
    assign bit_tick = (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign pre_tick = (cnt_q == CW'(CLKS_PER_BIT - 2));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || bit_tick) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops bytes from a show-ahead FIFO and shifts each out as an async serial frame.
// Define FIFO_TX_PARITY_EN to insert an even-parity bit after the data bits.
module fifo_serial_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              empty,
    input  logic [DATA_W-1:0] data_in,
    output logic              rd,
    output logic              tx,
    output logic              busy,
    output logic              done
);
    import fifo_tx_pkg::*;

    localparam int BCW = $clog2(DATA_W + 1);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              bit_tick, pre_tick, baud_clr;
`ifdef FIFO_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    assign baud_clr = (state_q == IDLE);

    fifo_tx_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (baud_clr),
        .bit_tick (bit_tick),
        .pre_tick (pre_tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        rd        = 1'b0;
`ifdef FIFO_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            IDLE: if (enable && !empty) begin
                rd        = 1'b1;
                shreg_d   = data_in;
                bit_cnt_d = '0;
`ifdef FIFO_TX_PARITY_EN
                par_d     = ^data_in;
`endif
                state_d   = START;
            end
            START: if (bit_tick) begin
                bit_cnt_d = '0;
                state_d   = DATA;
            end
            DATA: if (bit_tick) begin
                if (bit_cnt_q == BCW'(DATA_W - 1)) begin
                    bit_cnt_d = '0;
`ifdef FIFO_TX_PARITY_EN
                    state_d   = PARITY;
`else
                    state_d   = STOP;
`endif
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    shreg_d   = shreg_q >> 1;
                end
            end
`ifdef FIFO_TX_PARITY_EN
            PARITY: if (bit_tick) state_d = STOP;
`endif
            STOP: begin
                // Registered done must rise one clk early to sit on the final clk.
                if (pre_tick && bit_cnt_q == BCW'(STOP_BITS - 1)) done_d = 1'b1;
                if (bit_tick) begin
                    if (bit_cnt_q == BCW'(STOP_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the next state so tx falls the clk after the pop.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
`ifdef FIFO_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            STOP:    tx_d = 1'b1;
            default: tx_d = TX_IDLE_LEVEL;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= TX_IDLE_LEVEL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef FIFO_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef FIFO_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
